alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (legal values 8..64).
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request; sampled only while busy=0.
REQ-005 Port: ALUctrlop  input  4  operation code, latched with start.
REQ-006 Port: in0, in1  input  WIDTH  operands, latched with start.
REQ-007 Port: ALUresult  output  WIDTH  registered result, or low product / quotient.
REQ-008 Port: hi  output  WIDTH  registered high product / remainder; 0 for single-cycle ops.
REQ-009 Port: Zero  output  1  registered; 1 when the new ALUresult is 0.
REQ-010 Port: Overflow  output  1  registered; signed overflow of add/sub, else 0.
REQ-011 Port: busy  output  1  high from the cycle after an accepted start until done.
REQ-012 Port: done  output  1  one-cycle pulse; results valid from this cycle until the next done.

Function
REQ-013 Opcodes: 0000 and; 0001 or; 0010 add; 0110 sub; 0111 slt (signed); 0011 sltu (unsigned); 1000 nor; 1010 multu; 1011 divu; other codes give result 0.
REQ-014 Single-cycle ops: start accepted at edge k; outputs updated and done=1 at edge k+1; busy stays 0.
REQ-015 States: IDLE, MUL, DIV. IDLE->MUL on start with 1010; IDLE->DIV on start with 1011; MUL/DIV->IDLE after WIDTH iterations.
REQ-016 multu: shift-add, one bit per cycle, unsigned 2*WIDTH product; hi=upper half, ALUresult=lower half; done WIDTH+1 edges after accept.
REQ-017 divu: restoring division, one bit per cycle, unsigned; ALUresult=quotient, hi=remainder; done WIDTH+1 edges after accept.
REQ-018 divu with in1=0: no iteration; ALUresult=all ones, hi=in0, done at edge k+1.
REQ-019 start while busy=1 is ignored; operand or opcode changes during MUL/DIV do not affect the result.
REQ-020 start in the same cycle as done (busy falling) is accepted; back-to-back single-cycle ops give done on consecutive cycles.
REQ-021 Arithmetic wraps modulo 2^WIDTH; Overflow=1 when add/sub sign rules are violated; Zero is evaluated on ALUresult only.
REQ-022 ALUresult, hi, Zero and Overflow hold their values between done pulses.

Reset
REQ-023 rst_n=0 asynchronously forces state IDLE, busy=0, done=0, ALUresult=0, hi=0, Overflow=0, Zero=1.
REQ-024 Reset during MUL/DIV aborts the operation; no done pulse follows; the first start after release is accepted normally.

Verification
REQ-025 WIDTH=32, add 0x7FFFFFFF+0x00000001 -> ALUresult=0x80000000, Overflow=1, Zero=0, done at k+1.
REQ-026 sub 5-5 -> ALUresult=0, Zero=1, Overflow=0; slt 0xFFFFFFFF,1 -> 1; sltu with the same operands -> 0.
REQ-027 multu 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, ALUresult=0x00000001, done exactly 33 edges after accept, busy high for 32 cycles.
REQ-028 divu 100/7 -> ALUresult=14, hi=2 after 33 edges; divu 100/0 -> ALUresult=0xFFFFFFFF, hi=100 at k+1.
REQ-029 start pulses and operand changes during multu -> ignored, original product returned; start in the done cycle -> accepted.
REQ-030 rst_n low 10 cycles into divu -> outputs reset immediately, no done pulse; next add 2+3 -> ALUresult=5.

Source files
------------

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc
// Purpose  : Multi-cycle ALU with single-cycle logic/arith ops, shift-add
//            unsigned multiply and restoring unsigned divide.
// Revision : 1.0
// ============================================================================
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ALUctrlop,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] ALUresult,
  output logic [WIDTH-1:0] hi,
  output logic             Zero,
  output logic             Overflow,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] c_op_and   = 4'b0000;
  localparam logic [3:0] c_op_or    = 4'b0001;
  localparam logic [3:0] c_op_add   = 4'b0010;
  localparam logic [3:0] c_op_sub   = 4'b0110;
  localparam logic [3:0] c_op_slt   = 4'b0111;
  localparam logic [3:0] c_op_sltu  = 4'b0011;
  localparam logic [3:0] c_op_nor   = 4'b1000;
  localparam logic [3:0] c_op_multu = 4'b1010;
  localparam logic [3:0] c_op_divu  = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  // Request staged here for one cycle; the operation executes on the next edge.
  logic             r_pend;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  // Iterative datapath: r_acc = product high / partial remainder,
  // r_q = multiplier shifting out / quotient shifting in.
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;

  logic             w_is_mul;
  logic             w_is_div_iter;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;

  logic [WIDTH:0]   w_madd;
  logic [WIDTH-1:0] w_mul_acc;
  logic [WIDTH-1:0] w_mul_q;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_dsub;
  logic             w_ge;
  logic [WIDTH-1:0] w_div_acc;
  logic [WIDTH-1:0] w_div_q;

  assign w_is_mul      = (r_op == c_op_multu);
  assign w_is_div_iter = (r_op == c_op_divu) && (r_b != '0);

  // A staged multi-cycle request must block new starts even though busy is
  // still low during the staging cycle.
  assign w_accept = start && (r_state == S_IDLE) &&
                    !(r_pend && (w_is_mul || w_is_div_iter));
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign busy     = (r_state != S_IDLE);

  assign w_sum  = r_a + r_b;
  assign w_diff = r_a - r_b;

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (r_op)
      c_op_and:  w_res = r_a & r_b;
      c_op_or:   w_res = r_a | r_b;
      c_op_nor:  w_res = ~(r_a | r_b);
      c_op_add: begin
        w_res = w_sum;
        w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      c_op_sub: begin
        w_res = w_diff;
        w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
      end
      c_op_slt:  w_res = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
      c_op_sltu: w_res = {{(WIDTH-1){1'b0}}, (r_a < r_b)};
      default:   w_res = '0;
    endcase
  end

  // Shift-add step: add multiplicand when the current multiplier bit is set,
  // then shift the {acc, q} pair right by one.
  assign w_madd    = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
  assign w_mul_acc = w_madd[WIDTH:1];
  assign w_mul_q   = {w_madd[0], r_q[WIDTH-1:1]};

  // Restoring step: remainder < divisor keeps the trial difference in WIDTH bits.
  assign w_shift   = {r_acc, r_q[WIDTH-1]};
  assign w_dsub    = w_shift - {1'b0, r_b};
  assign w_ge      = ~w_dsub[WIDTH];
  assign w_div_acc = w_ge ? w_dsub[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_div_q   = {r_q[WIDTH-2:0], w_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_pend && w_is_mul)           w_next = S_MUL;
        else if (r_pend && w_is_div_iter) w_next = S_DIV;
      end
      S_MUL, S_DIV: begin
        if (w_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend    <= 1'b0;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_cnt     <= '0;
      ALUresult <= '0;
      hi        <= '0;
      Zero      <= 1'b1;
      Overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done   <= 1'b0;
      r_pend <= w_accept;
      if (w_accept) begin
        r_op <= ALUctrlop;
        r_a  <= in0;
        r_b  <= in1;
      end
      case (r_state)
        S_IDLE: begin
          if (r_pend) begin
            if (w_is_mul || w_is_div_iter) begin
              r_acc <= '0;
              r_q   <= r_a;
              r_cnt <= '0;
            end else if (r_op == c_op_divu) begin
              ALUresult <= '1;
              hi        <= r_a;
              Zero      <= 1'b0;
              Overflow  <= 1'b0;
              done      <= 1'b1;
            end else begin
              ALUresult <= w_res;
              hi        <= '0;
              Zero      <= (w_res == '0);
              Overflow  <= w_ovf;
              done      <= 1'b1;
            end
          end
        end
        S_MUL: begin
          r_acc <= w_mul_acc;
          r_q   <= w_mul_q;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            ALUresult <= w_mul_q;
            hi        <= w_mul_acc;
            Zero      <= (w_mul_q == '0);
            Overflow  <= 1'b0;
            done      <= 1'b1;
          end
        end
        S_DIV: begin
          r_acc <= w_div_acc;
          r_q   <= w_div_q;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            ALUresult <= w_div_q;
            hi        <= w_div_acc;
            Zero      <= (w_div_q == '0);
            Overflow  <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mc
// Purpose  : Directed self-checking bench for alu_mc (WIDTH=32).
// Revision : 1.0
// ============================================================================
module tb_alu_mc;

  localparam logic [3:0] c_and   = 4'b0000;
  localparam logic [3:0] c_or    = 4'b0001;
  localparam logic [3:0] c_add   = 4'b0010;
  localparam logic [3:0] c_sub   = 4'b0110;
  localparam logic [3:0] c_slt   = 4'b0111;
  localparam logic [3:0] c_sltu  = 4'b0011;
  localparam logic [3:0] c_nor   = 4'b1000;
  localparam logic [3:0] c_multu = 4'b1010;
  localparam logic [3:0] c_divu  = 4'b1011;
  localparam logic [3:0] c_undef = 4'b0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  ALUctrlop;
  logic [31:0] in0;
  logic [31:0] in1;
  logic [31:0] ALUresult;
  logic [31:0] hi;
  logic        Zero;
  logic        Overflow;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  alu_mc #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ALUctrlop (ALUctrlop),
    .in0       (in0),
    .in1       (in1),
    .ALUresult (ALUresult),
    .hi        (hi),
    .Zero      (Zero),
    .Overflow  (Overflow),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a request for one edge (edge k); returns 1ns after edge k.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; ALUctrlop = op; in0 = a; in1 = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after the accept edge until done, sampling busy after each.
  task automatic wait_done(input int bound, output int edges, output int busy_cyc);
    edges = 0;
    busy_cyc = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (busy) busy_cyc++;
    end while (!done && edges < bound);
  endtask

  initial begin
    int edges;
    int bcyc;
    int dcount;

    rst_n = 1'b0; start = 1'b0; ALUctrlop = '0; in0 = '0; in1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", {32'd0, ALUresult}, 64'd0);
    chk("rst_hi",     {32'd0, hi},        64'd0);
    chk("rst_zero",   {63'd0, Zero},      64'd1);
    chk("rst_ovf",    {63'd0, Overflow},  64'd0);
    chk("rst_busy",   {63'd0, busy},      64'd0);
    chk("rst_done",   {63'd0, done},      64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Signed overflow on add
    issue(c_add, 32'h7FFF_FFFF, 32'h0000_0001);
    chk("add_nodone_k", {63'd0, done}, 64'd0);
    wait_done(5, edges, bcyc);
    chk("add_latency", edges,              1);
    chk("add_result",  {32'd0, ALUresult}, 64'h8000_0000);
    chk("add_ovf",     {63'd0, Overflow},  64'd1);
    chk("add_zero",    {63'd0, Zero},      64'd0);
    chk("add_hi",      {32'd0, hi},        64'd0);
    chk("add_busy",    bcyc,               0);
    @(posedge clk);
    #1;
    chk("hold_done",   {63'd0, done},      64'd0);
    chk("hold_result", {32'd0, ALUresult}, 64'h8000_0000);

    // sub 5-5, then back-to-back slt / sltu / and / or / nor / undefined
    issue(c_sub, 32'd5, 32'd5);
    wait_done(5, edges, bcyc);
    chk("sub_result", {32'd0, ALUresult}, 64'd0);
    chk("sub_zero",   {63'd0, Zero},      64'd1);
    chk("sub_ovf",    {63'd0, Overflow},  64'd0);

    issue(c_slt, 32'hFFFF_FFFF, 32'd1);
    issue(c_sltu, 32'hFFFF_FFFF, 32'd1);
    chk("b2b_slt_done", {63'd0, done},      64'd1);
    chk("slt_result",   {32'd0, ALUresult}, 64'd1);
    chk("slt_zero",     {63'd0, Zero},      64'd0);
    issue(c_and, 32'hF0F0_1234, 32'h0FF0_FF00);
    chk("b2b_sltu_done", {63'd0, done},      64'd1);
    chk("sltu_result",   {32'd0, ALUresult}, 64'd0);
    chk("sltu_zero",     {63'd0, Zero},      64'd1);
    issue(c_or, 32'hF000_0001, 32'h0000_0100);
    chk("and_result", {32'd0, ALUresult}, 64'h00F0_1200);
    issue(c_nor, 32'hFFFF_0000, 32'h0000_00FF);
    chk("or_result",  {32'd0, ALUresult}, 64'hF000_0101);
    issue(c_undef, 32'h1234_5678, 32'h9ABC_DEF0);
    chk("nor_result", {32'd0, ALUresult}, 64'h0000_FF00);
    wait_done(5, edges, bcyc);
    chk("undef_result", {32'd0, ALUresult}, 64'd0);
    chk("undef_zero",   {63'd0, Zero},      64'd1);

    // Signed overflow on sub
    issue(c_sub, 32'h8000_0000, 32'd1);
    wait_done(5, edges, bcyc);
    chk("subov_result", {32'd0, ALUresult}, 64'h7FFF_FFFF);
    chk("subov_ovf",    {63'd0, Overflow},  64'd1);

    // multu with start pulses and operand/opcode changes while running
    issue(c_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    edges = 0;
    bcyc  = 0;
    forever begin
      @(posedge clk);
      #1;
      edges++;
      if (busy) bcyc++;
      if (done || edges >= 100) break;
      @(negedge clk);
      start = edges[0]; ALUctrlop = (edges[1] ? c_add : c_divu);
      in0 = 32'h0000_0003 + edges; in1 = 32'h0000_0011;
    end
    chk("mul_latency", edges,              33);
    chk("mul_busy",    bcyc,               32);
    chk("mul_lo",      {32'd0, ALUresult}, 64'h0000_0001);
    chk("mul_hi",      {32'd0, hi},        64'hFFFF_FFFE);
    chk("mul_ovf",     {63'd0, Overflow},  64'd0);

    // Start issued in the done cycle is accepted
    issue(c_add, 32'd2, 32'd3);
    chk("mul_hold_lo", {32'd0, ALUresult}, 64'h0000_0001);
    wait_done(5, edges, bcyc);
    chk("donecyc_latency", edges,              1);
    chk("donecyc_result",  {32'd0, ALUresult}, 64'd5);
    chk("donecyc_hi",      {32'd0, hi},        64'd0);

    // divu 100/7
    issue(c_divu, 32'd100, 32'd7);
    wait_done(100, edges, bcyc);
    chk("div_latency", edges,              33);
    chk("div_busy",    bcyc,               32);
    chk("div_q",       {32'd0, ALUresult}, 64'd14);
    chk("div_r",       {32'd0, hi},        64'd2);

    // divu by zero
    issue(c_divu, 32'd100, 32'd0);
    wait_done(5, edges, bcyc);
    chk("div0_latency", edges,              1);
    chk("div0_q",       {32'd0, ALUresult}, 64'hFFFF_FFFF);
    chk("div0_r",       {32'd0, hi},        64'd100);
    chk("div0_zero",    {63'd0, Zero},      64'd0);

    // Reset 10 cycles into a divide
    issue(c_divu, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_result", {32'd0, ALUresult}, 64'd0);
    chk("abort_hi",     {32'd0, hi},        64'd0);
    chk("abort_zero",   {63'd0, Zero},      64'd1);
    chk("abort_busy",   {63'd0, busy},      64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    chk("abort_nodone", dcount, 0);
    issue(c_add, 32'd2, 32'd3);
    wait_done(5, edges, bcyc);
    chk("post_abort_latency", edges,              1);
    chk("post_abort_result",  {32'd0, ALUresult}, 64'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
